// File: rtl/pls_nios2_gen2_0_cpu_debug_mon_access.sv
// Debug monitor RAM access: turns JTAG ocimem commands into monitor-RAM word reads/writes
// and arbitrates the same RAM with the CPU Avalon debug slave (JTAG first).
module pls_nios2_gen2_0_cpu_debug_mon_access #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, J_RD, C_RD, C_ACK} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_mon_a;
    logic              r_pend_rd;
    logic              r_pend_wr;

    logic w_jcmd;
    logic w_idle_free;
    logic w_j_wr;
    logic w_j_rd;
    logic w_c_wr;
    logic w_c_rd;

    // A command arriving this cycle supersedes whatever is pending, so nothing is issued
    // from IDLE until it has been registered.
    assign w_jcmd      = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_idle_free = (r_state == IDLE) && !w_jcmd;
    assign w_j_wr      = w_idle_free && r_pend_wr;
    assign w_j_rd      = w_idle_free && !r_pend_wr && r_pend_rd;
    assign w_c_wr      = w_idle_free && !r_pend_wr && !r_pend_rd && avs_write;
    assign w_c_rd      = w_idle_free && !r_pend_wr && !r_pend_rd && !avs_write && avs_read;

    always_comb begin
        ram_rd          = 1'b0;
        ram_wr          = 1'b0;
        ram_addr        = r_mon_a;
        ram_wdata       = MonDReg;
        ram_be          = 4'hF;
        avs_waitrequest = 1'b1;
        if (w_j_wr) begin
            ram_wr = 1'b1;
        end else if (w_j_rd) begin
            ram_rd = 1'b1;
        end else if (w_c_wr) begin
            ram_wr          = 1'b1;
            ram_addr        = avs_address;
            ram_wdata       = avs_writedata;
            ram_be          = avs_byteenable;
            avs_waitrequest = 1'b0;
        end else if (w_c_rd) begin
            ram_rd   = 1'b1;
            ram_addr = avs_address;
        end
        if (r_state == C_ACK) avs_waitrequest = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_mon_a      <= '0;
            r_pend_rd    <= 1'b0;
            r_pend_wr    <= 1'b0;
            MonDReg      <= 32'h0;
            avs_readdata <= 32'h0;
            jtag_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_j_rd)      r_state <= J_RD;
                    else if (w_c_rd) r_state <= C_RD;
                end
                J_RD: begin
                    MonDReg <= ram_rdata;
                    r_state <= IDLE;
                end
                C_RD: begin
                    avs_readdata <= ram_rdata;
                    r_state      <= C_ACK;
                end
                default: r_state <= IDLE;
            endcase

            if (w_j_wr) begin
                r_pend_wr <= 1'b0;
                r_mon_a   <= r_mon_a + ADDR_W'(1);
            end
            if (w_j_rd) r_pend_rd <= 1'b0;

            // Commands land after the FSM updates so a new write word beats a J_RD capture.
            if (take_action_ocimem_b) begin
                MonDReg   <= jdo[34:3];
                r_pend_wr <= 1'b1;
                r_pend_rd <= 1'b0;
            end else if (take_action_ocimem_a) begin
                r_mon_a   <= jdo[ADDR_W+8:9];
                r_pend_rd <= 1'b1;
                r_pend_wr <= 1'b0;
            end else if (take_no_action_ocimem_a) begin
                r_mon_a   <= r_mon_a + ADDR_W'(1);
                r_pend_rd <= 1'b1;
                r_pend_wr <= 1'b0;
            end

            if (w_jcmd && (r_pend_rd || r_pend_wr || r_state == J_RD)) jtag_overrun <= 1'b1;
        end
    end

endmodule
